// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter in front of a single CPU-side memory bus.
//                Each port latches one outstanding request; a three-state FSM
//                issues one downstream transaction at a time with round-robin
//                or fixed priority and a bus-timeout watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  // port 0 (instruction fetch)
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  // port 1 (data / DMA)
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  // downstream bus
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready,
  output logic        bus_error
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit when the
  // watchdog is tiny or disabled.
  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned     TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  // Per-port latched request, index 0 = m0, index 1 = m1
  logic [1:0]       r_pend;
  logic [1:0]       r_instr;
  logic [1:0][31:0] r_addr;
  logic [1:0][31:0] r_wdata;
  logic [1:0][3:0]  r_wstrb;

  logic             r_grant;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;

  // Port inputs gathered into arrays so both ports share one capture loop
  logic [1:0]       w_in_valid;
  logic [1:0]       w_in_instr;
  logic [1:0][31:0] w_in_addr;
  logic [1:0][31:0] w_in_wdata;
  logic [1:0][3:0]  w_in_wstrb;

  logic             w_sel;
  logic             w_timeout;
  logic             w_done;
  logic             w_err;
  logic             w_finish;

  assign w_in_valid = {m1_valid, m0_valid};
  assign w_in_instr = {m1_instr, m0_instr};
  assign w_in_addr  = {m1_addr,  m0_addr};
  assign w_in_wdata = {m1_wdata, m0_wdata};
  assign w_in_wstrb = {m1_wstrb, m0_wstrb};

  // Grant selection from registered pend flags only (no same-cycle bypass)
  always_comb begin
    w_sel = 1'b0;
    if (r_pend[0] && r_pend[1]) begin
      if (FIXED_PRIO != 0) begin
        w_sel = 1'b0;
      end else begin
        w_sel = ~r_last;
      end
    end else if (r_pend[1]) begin
      w_sel = 1'b1;
    end
  end

  // Completion qualifiers: a real response always wins over the watchdog
  always_comb begin
    w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    w_done    = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && memory_ready;
    w_err     = (r_state == S_WAIT) && !memory_ready && w_timeout;
    w_finish  = w_done || w_err;
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pend != 2'b00) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (memory_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_finish) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM outputs: downstream request fields and per-port completion
  always_comb begin
    memory_valid = 1'b0;
    memory_instr = 1'b0;
    memory_addr  = 32'd0;
    memory_wdata = 32'd0;
    memory_wstrb = 4'd0;
    m0_ready     = 1'b0;
    m0_rdata     = 32'd0;
    m1_ready     = 1'b0;
    m1_rdata     = 32'd0;
    bus_error    = w_err;
    if (r_state == S_ISSUE) begin
      memory_valid = 1'b1;
      memory_instr = r_instr[r_grant];
      memory_addr  = r_addr[r_grant];
      memory_wdata = r_wdata[r_grant];
      memory_wstrb = r_wstrb[r_grant];
    end
    if (w_finish) begin
      if (r_grant) begin
        m1_ready = 1'b1;
        m1_rdata = w_done ? memory_rdata : 32'd0;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = w_done ? memory_rdata : 32'd0;
      end
    end
  end

  // Request capture: a valid while already pending is dropped untouched
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend  <= 2'b00;
      r_instr <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_in_valid[p] && !r_pend[p]) begin
          r_pend[p]  <= 1'b1;
          r_instr[p] <= w_in_instr[p];
          r_addr[p]  <= w_in_addr[p];
          r_wdata[p] <= w_in_wdata[p];
          r_wstrb[p] <= w_in_wstrb[p];
        end else if (w_finish && (r_grant == 1'(p))) begin
          r_pend[p]  <= 1'b0;
        end
      end
    end
  end

  // Grant, round-robin history and watchdog counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      if ((r_state == S_IDLE) && (r_pend != 2'b00)) begin
        r_grant <= w_sel;
      end
      if (w_finish) begin
        r_last <= r_grant;
        r_cnt  <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Two instances share the
//                stimulus: index 0 is round-robin, index 1 is fixed priority,
//                both with an 8-cycle watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;

  logic [1:0]       mv, mi, r0, r1, be;
  logic [1:0][31:0] ma, mw, rd0, rd1;
  logic [1:0][3:0]  ms;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TO)) dut_rr (
    .clock(clock), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(rd0[0]), .m0_ready(r0[0]),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(rd1[0]), .m1_ready(r1[0]),
    .memory_valid(mv[0]), .memory_instr(mi[0]), .memory_addr(ma[0]),
    .memory_wdata(mw[0]), .memory_wstrb(ms[0]), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready), .bus_error(be[0])
  );

  mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TO)) dut_fp (
    .clock(clock), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(rd0[1]), .m0_ready(r0[1]),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(rd1[1]), .m1_ready(r1[1]),
    .memory_valid(mv[1]), .memory_instr(mi[1]), .memory_addr(ma[1]),
    .memory_wdata(mw[1]), .memory_wstrb(ms[1]), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready), .bus_error(be[1])
  );

  task automatic chk(input int k, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h, required %0h", (k != 0) ? "fp" : "rr",
               name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Transaction view: each port holds at most one queued request; an arbiter
  // is either free (m_cur = -1) or serving port m_cur, m_age cycles after
  // the downstream request went out.
  logic [1:0]  m_pend [2];
  logic        m_instr [2][2];
  logic [31:0] m_addr [2][2];
  logic [31:0] m_wdata [2][2];
  logic [3:0]  m_wstrb [2][2];
  int          m_cur [2] = '{-1, -1};
  int          m_age [2] = '{0, 0};
  int          m_last [2] = '{1, 1};

  logic [31:0] log_rr [$];
  logic [31:0] log_fp [$];

  logic        e_mv, e_mi, e_r0, e_r1, e_be, c_done, c_err;
  logic [31:0] e_ma, e_mw, e_rd0, e_rd1;
  logic [3:0]  e_ms;
  logic [1:0]  op;
  int          g;

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pend[k] = 2'b00;
        m_cur[k]  = -1;
        m_age[k]  = 0;
        m_last[k] = 1;
      end
      e_mv = 0; e_mi = 0; e_ma = 0; e_mw = 0; e_ms = 0;
      e_r0 = 0; e_r1 = 0; e_rd0 = 0; e_rd1 = 0; e_be = 0;
      c_done = 0; c_err = 0;
      g = m_cur[k];
      if (g >= 0) begin
        if (m_age[k] == 0) begin
          e_mv = 1;
          e_mi = m_instr[k][g];
          e_ma = m_addr[k][g];
          e_mw = m_wdata[k][g];
          e_ms = m_wstrb[k][g];
        end
        c_done = memory_ready;
        c_err  = !memory_ready && (m_age[k] == TO);
        if (c_done || c_err) begin
          if (g == 0) begin
            e_r0 = 1; e_rd0 = c_done ? memory_rdata : 32'd0;
          end else begin
            e_r1 = 1; e_rd1 = c_done ? memory_rdata : 32'd0;
          end
        end
        e_be = c_err;
      end
      chk(k, "memory_valid", mv[k], e_mv);
      chk(k, "memory_instr", mi[k], e_mi);
      chk(k, "memory_addr",  ma[k], e_ma);
      chk(k, "memory_wdata", mw[k], e_mw);
      chk(k, "memory_wstrb", ms[k], e_ms);
      chk(k, "m0_ready", r0[k], e_r0);
      chk(k, "m0_rdata", rd0[k], e_rd0);
      chk(k, "m1_ready", r1[k], e_r1);
      chk(k, "m1_rdata", rd1[k], e_rd1);
      chk(k, "bus_error", be[k], e_be);
      if (mv[k] === 1'b1) begin
        if (k == 0) log_rr.push_back(ma[k]);
        else        log_fp.push_back(ma[k]);
      end
      // advance to what the next clock edge must produce
      if (!reset) begin
        op = m_pend[k];
        if (g >= 0) begin
          if (c_done || c_err) begin
            m_pend[k][g] = 1'b0;
            m_last[k]    = g;
            m_cur[k]     = -1;
          end else begin
            m_age[k]++;
          end
        end else if (op != 2'b00) begin
          if (op == 2'b11) m_cur[k] = (k == 1) ? 0 : ((m_last[k] == 0) ? 1 : 0);
          else             m_cur[k] = op[0] ? 0 : 1;
          m_age[k] = 0;
        end
        if (m0_valid && !op[0]) begin
          m_pend[k][0] = 1'b1;
          m_instr[k][0] = m0_instr; m_addr[k][0] = m0_addr;
          m_wdata[k][0] = m0_wdata; m_wstrb[k][0] = m0_wstrb;
        end
        if (m1_valid && !op[1]) begin
          m_pend[k][1] = 1'b1;
          m_instr[k][1] = m1_instr; m_addr[k][1] = m1_addr;
          m_wdata[k][1] = m1_wdata; m_wstrb[k][1] = m1_wstrb;
        end
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic cyc();
    @(posedge clock);
    #1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
  endtask

  task automatic req0(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic ins);
    m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s; m0_instr = ins;
  endtask

  task automatic req1(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic ins);
    m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s; m1_instr = ins;
  endtask

  logic [31:0] exp_pair [6];
  logic [31:0] exp_rr3 [3];
  logic [31:0] exp_fp3 [3];

  initial begin
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    memory_rdata = 0; memory_ready = 0;
    exp_pair = '{32'h1000, 32'h2000, 32'h1000, 32'h2000, 32'h1000, 32'h2000};
    exp_rr3  = '{32'h1000, 32'h2000, 32'h1000};
    exp_fp3  = '{32'h1000, 32'h1000, 32'h2000};

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk(0, "reset memory_valid", mv[0], 0);
    chk(0, "reset m0_ready", r0[0], 0);
    chk(1, "reset bus_error", be[1], 0);
    @(posedge clock); #1;
    reset = 0;
    cyc();

    // single read, slave answers one cycle after the request
    req0(32'h8000_0010, 32'd0, 4'h0, 1'b1);
    cyc(); cyc();
    @(negedge clock);
    chk(0, "read issue valid", mv[0], 1);
    chk(0, "read issue addr", ma[0], 32'h8000_0010);
    cyc();
    memory_ready = 1; memory_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    chk(0, "read m0_ready", r0[0], 1);
    chk(0, "read m0_rdata", rd0[0], 32'hDEAD_BEEF);
    cyc(); memory_ready = 0; memory_rdata = 0;
    cyc();

    // write passthrough on m1
    req1(32'h0200_4000, 32'h1234_5678, 4'hF, 1'b0);
    cyc(); cyc();
    @(negedge clock);
    chk(0, "write addr", ma[0], 32'h0200_4000);
    chk(0, "write wdata", mw[0], 32'h1234_5678);
    chk(0, "write wstrb", ms[0], 4'hF);
    cyc();
    @(negedge clock);
    chk(0, "write valid one cycle", mv[0], 0);
    cyc();
    memory_ready = 1; memory_rdata = 32'h0000_00AA;
    @(negedge clock);
    chk(0, "write m1_ready", r1[0], 1);
    chk(0, "write m0_ready idle", r0[0], 0);
    cyc(); memory_ready = 0; memory_rdata = 0;
    cyc();

    // simultaneous requests three times, zero-wait slave
    log_rr.delete(); log_fp.delete();
    memory_ready = 1; memory_rdata = 32'h5555_0000;
    for (int i = 0; i < 3; i++) begin
      req0(32'h1000, 32'd0, 4'h0, 1'b1);
      req1(32'h2000, 32'd0, 4'h0, 1'b0);
      repeat (5) cyc();
    end
    chk(0, "pair order count", log_rr.size(), 6);
    chk(1, "pair order count", log_fp.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk(0, "pair order", (i < log_rr.size()) ? log_rr[i] : 32'hFFFF_FFFF, exp_pair[i]);
      chk(1, "pair order", (i < log_fp.size()) ? log_fp[i] : 32'hFFFF_FFFF, exp_pair[i]);
    end

    // m0 alone, then contention right after an m0 grant
    log_rr.delete(); log_fp.delete();
    req0(32'h1000, 32'd0, 4'h0, 1'b1);
    cyc(); cyc();
    @(negedge clock);
    chk(0, "zero-wait m0_ready", r0[0], 1);
    cyc();
    req0(32'h1000, 32'd0, 4'h0, 1'b1);
    req1(32'h2000, 32'd0, 4'h0, 1'b0);
    repeat (5) cyc();
    memory_ready = 0; memory_rdata = 0;
    for (int i = 0; i < 3; i++) begin
      chk(0, "prio order", (i < log_rr.size()) ? log_rr[i] : 32'hFFFF_FFFF, exp_rr3[i]);
      chk(1, "prio order", (i < log_fp.size()) ? log_fp[i] : 32'hFFFF_FFFF, exp_fp3[i]);
    end

    // watchdog: slave never answers
    memory_rdata = 32'hFFFF_FFFF;
    req0(32'h3000, 32'd0, 4'h0, 1'b0);
    repeat (9) cyc();
    @(negedge clock);
    chk(0, "timeout early bus_error", be[0], 0);
    cyc();
    @(negedge clock);
    chk(0, "timeout bus_error", be[0], 1);
    chk(0, "timeout m0_ready", r0[0], 1);
    chk(0, "timeout m0_rdata", rd0[0], 0);
    cyc();
    @(negedge clock);
    chk(0, "timeout back to idle", be[0], 0);
    memory_rdata = 0;
    cyc();

    // protocol violation and stray ready
    log_rr.delete();
    req0(32'h4, 32'd0, 4'h0, 1'b0);
    cyc();
    req0(32'h10, 32'd0, 4'h0, 1'b0);
    cyc();
    @(negedge clock);
    chk(0, "violation addr", ma[0], 32'h4);
    cyc();
    memory_ready = 1; memory_rdata = 32'h77;
    cyc();
    memory_ready = 0;
    repeat (2) cyc();
    memory_ready = 1; memory_rdata = 32'h9999;
    @(negedge clock);
    chk(0, "stray m0_ready", r0[0], 0);
    chk(0, "stray m1_ready", r1[0], 0);
    cyc(); memory_ready = 0;
    cyc();
    chk(0, "violation issue count", log_rr.size(), 1);

    // reset in the middle of a wait
    req1(32'h5000, 32'd0, 4'h0, 1'b0);
    repeat (4) cyc();
    reset = 1;
    @(negedge clock);
    chk(0, "mid reset m1_ready", r1[0], 0);
    chk(0, "mid reset memory_valid", mv[0], 0);
    cyc();
    reset = 0;
    cyc();
    memory_ready = 1; memory_rdata = 32'h1111;
    @(negedge clock);
    chk(0, "late ready m1_ready", r1[0], 0);
    cyc(); memory_ready = 0;
    req1(32'h6000, 32'd0, 4'h0, 1'b0);
    cyc(); cyc();
    memory_ready = 1; memory_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    chk(0, "after reset m1_ready", r1[0], 1);
    chk(0, "after reset m1_rdata", rd1[0], 32'hCAFE_F00D);
    cyc(); memory_ready = 0; memory_rdata = 0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus, required $finish before 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single CPU-side memory bus (valid/instr/addr/wdata/wstrb → rdata/ready) in front of the SoC address decoder.
- Port m0 carries instruction fetch; port m1 carries data or DMA.
- Each port latches one outstanding request. A 3-state FSM issues one transaction at a time downstream, with round-robin or fixed priority and a bus-timeout watchdog.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins when both pending
TIMEOUT, 1024, cycles in WAIT without memory_ready before forced error completion; 0 = watchdog disabled

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
m0_valid  in  1  one-cycle request pulse, port 0
m0_instr  in  1  instruction-fetch flag, port 0
m0_addr  in  32  byte address, port 0
m0_wdata  in  32  write data, port 0
m0_wstrb  in  4  byte strobes; 0 = read, port 0
m0_rdata  out  32  read data, valid only with m0_ready
m0_ready  out  1  one-cycle completion pulse, port 0
m1_valid/m1_instr/m1_addr/m1_wdata/m1_wstrb/m1_rdata/m1_ready  same as m0, port 1
memory_valid  out  1  downstream request pulse
memory_instr  out  1  downstream instr flag
memory_addr  out  32  downstream address
memory_wdata  out  32  downstream write data
memory_wstrb  out  4  downstream strobes
memory_rdata  in  32  downstream read data
memory_ready  in  1  downstream completion pulse
bus_error  out  1  one-cycle pulse when a watchdog timeout completes a transaction

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high; ports are named clock and reset.
- Reset clears state to IDLE, both pend flags, all request registers, last_grant=1 and the timeout counter.
- During and after reset, all outputs are 0.
- Capture: mX_valid=1 with pendX=0 sets pendX and latches instr/addr/wdata/wstrb at the clock edge.
- mX_valid while pendX=1 is a protocol violation: the request is ignored and the latched fields are unchanged.
- FSM IDLE:
  - If no pend flag is set, stay in IDLE.
  - Otherwise select grant and go to ISSUE.
  - Only pend flags already registered are considered; a same-cycle valid is not bypassed.
- Grant rule:
  - Only one port pending → that port.
  - Both pending, FIXED_PRIO=1 → m0.
  - Both pending, FIXED_PRIO=0 → the port != last_grant.
- FSM ISSUE:
  - memory_valid=1 for exactly this cycle.
  - memory_* fields are driven from the granted port's latched registers; in all other states memory_* fields are 0.
  - If memory_ready=1 in this cycle, complete (see below) and go to IDLE; else go to WAIT.
- FSM WAIT:
  - memory_valid=0; timeout counter increments each cycle.
  - memory_ready=1 → complete, go to IDLE.
  - Counter reaches TIMEOUT-1 with no ready (TIMEOUT>0) → error-complete, go to IDLE.
- Complete:
  - Combinational in the same cycle: mG_ready=1, mG_rdata=memory_rdata.
  - At the edge: clear pendG, last_grant=G, counter=0.
  - The non-granted port's mX_ready stays 0 and its mX_rdata stays 0.
- Error-complete:
  - Same as complete, but mG_rdata=0 and bus_error=1 for one cycle.
- memory_ready in IDLE is ignored (stray or late response); no state change.
- Latency:
  - valid at cycle N → memory_valid at N+2.
  - Zero-wait slave → mX_ready at N+2.
  - Back-to-back grants are separated by at least one IDLE cycle.
- New request on the completing port in the completion cycle: pendX is still 1, so the request is ignored. The requester must wait for ready before re-issuing.
- Reset asserted mid-transaction abandons the transaction; no ready is returned to either port.

Test Plan:
- Single read: m0_valid, addr=0x8000_0010, wstrb=0; slave ready 1 cycle after memory_valid, rdata=0xDEAD_BEEF → memory_valid at N+2 with addr 0x8000_0010; m0_ready=1, m0_rdata=0xDEAD_BEEF at N+3.
- Simultaneous requests, FIXED_PRIO=0: m0 and m1 valid in the same cycle, three times in succession → grant order m0, m1, m0, m1, m0, m1. With FIXED_PRIO=1 under continuous contention → m0 served each time m0 is pending.
- Write passthrough: m1_valid, addr=0x0200_4000, wdata=0x1234_5678, wstrb=0xF → memory_* carries identical values for exactly one cycle; m1_ready pulses on memory_ready; m0_ready stays 0.
- Timeout: TIMEOUT=8, slave never ready → m0_ready=1, m0_rdata=0, bus_error=1 exactly 8 cycles after entering WAIT; FSM returns to IDLE.
- Protocol violation and stray ready: second m0_valid with addr=0x10 while m0 is pending on addr=0x4 → downstream sees only 0x4. memory_ready pulsed in IDLE → no mX_ready.
- Reset mid-WAIT: assert reset while waiting → all outputs 0 immediately; a later memory_ready produces no mX_ready; a fresh request after reset completes normally.
